dma_engine: RTL and testbench

Single-channel word-serial DMA between DRAM and the global buffer (GLB). It sits directly downstream of the tile scheduler's DMA port and executes each filter, ifmap, bias or opsum transfer that the scheduler issues. It signals completion on `dma_interrupt_o`, which the scheduler consumes as its `dma_interrupt_i`. One command is in flight at a time, with one 32-bit word moved per beat.

---
 rtl/dma_pkg.sv | 36 +++
 rtl/dma_engine.sv | 160 ++++++++++++++++
 tb/tb_dma_engine.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/dma_pkg.sv
// Shared types and helpers for the single-channel DRAM <-> GLB DMA engine.
// States, word constants and the tail-strobe function.
package dma_pkg;

    typedef enum logic [3:0] {
        IDLE,
        RD_REQ,
        RD_WAIT,
        GLB_WR,
        GR_REQ,
        GR_WAIT,
        WR_REQ,
        DONE,
        HOLD
    } dma_state_e;

    localparam int         WORD_BYTES = 4;
    localparam logic [3:0] STRB_FULL  = 4'hF;

    function automatic logic [3:0] strb_for(input logic [31:0] rem);
        logic [3:0] s;
        s = 4'h0;
        if (rem >= 32'(WORD_BYTES)) begin
            s = STRB_FULL;
        end else begin
            unique case (rem[1:0])
                2'd1:    s = 4'h1;
                2'd2:    s = 4'h3;
                2'd3:    s = 4'h7;
                default: s = 4'h0;
            endcase
        end
        return s;
    endfunction

endpackage

// File: rtl/dma_engine.sv
// Word-serial DMA: moves one 32-bit word per beat between DRAM and the GLB.
// One command in flight; completion is a one-cycle interrupt pulse.
module dma_engine
    import dma_pkg::*;
#(
    parameter int GLB_AW = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              dma_enable_i,
    input  logic              dma_read_i,
    input  logic [31:0]       dma_addr_i,
    input  logic [31:0]       dma_len_i,
    input  logic [GLB_AW-1:0] glb_addr_i,
    output logic              dma_interrupt_o,
    output logic              dma_err_o,
    output logic              busy_o,
    output logic              dram_req_o,
    output logic              dram_we_o,
    output logic [31:0]       dram_addr_o,
    output logic [31:0]       dram_wdata_o,
    output logic [3:0]        dram_wstrb_o,
    input  logic              dram_gnt_i,
    input  logic              dram_rvalid_i,
    input  logic [31:0]       dram_rdata_i,
    output logic              glb_we_o,
    output logic              glb_re_o,
    output logic [GLB_AW-1:0] glb_addr_o,
    output logic [31:0]       glb_wdata_o,
    output logic [3:0]        glb_wstrb_o,
    input  logic [31:0]       glb_rdata_i
);

    dma_state_e        state, next_state;
    logic [31:0]       rem_q;
    logic [31:0]       daddr_q;
    logic [GLB_AW-1:0] gaddr_q;
    logic [31:0]       data_q;
    logic              err_q;

    logic       accept;
    logic       misaligned;
    logic       last;
    logic       beat_done;
    logic [3:0] strb;

    assign accept     = (state == IDLE) && dma_enable_i;
    assign misaligned = (|dma_addr_i[1:0]) || (|glb_addr_i[1:0]);
    assign last       = rem_q <= 32'(WORD_BYTES);
    assign strb       = strb_for(rem_q);
    assign beat_done  = (state == GLB_WR) ||
                        ((state == WR_REQ) && dram_gnt_i);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rem_q   <= '0;
            daddr_q <= '0;
            gaddr_q <= '0;
            data_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            if (accept) begin
                rem_q   <= dma_len_i;
                daddr_q <= dma_addr_i;
                gaddr_q <= glb_addr_i;
                err_q   <= misaligned;
            end
            if ((state == RD_WAIT) && dram_rvalid_i) begin
                data_q <= dram_rdata_i;
            end
            if (state == GR_WAIT) begin
                data_q <= glb_rdata_i;
            end
            // Both address counters wrap silently at their widths.
            if (beat_done) begin
                rem_q   <= last ? '0 : rem_q - 32'(WORD_BYTES);
                daddr_q <= daddr_q + 32'(WORD_BYTES);
                gaddr_q <= gaddr_q + GLB_AW'(WORD_BYTES);
            end
        end
    end

    always_comb begin
        next_state = state;
        unique case (state)
            IDLE: begin
                if (dma_enable_i) begin
                    if (misaligned || (dma_len_i == '0)) begin
                        next_state = DONE;
                    end else begin
                        next_state = dma_read_i ? RD_REQ : GR_REQ;
                    end
                end
            end
            RD_REQ:  if (dram_gnt_i) next_state = RD_WAIT;
            RD_WAIT: if (dram_rvalid_i) next_state = GLB_WR;
            GLB_WR:  next_state = last ? DONE : RD_REQ;
            GR_REQ:  next_state = GR_WAIT;
            GR_WAIT: next_state = WR_REQ;
            WR_REQ: begin
                if (dram_gnt_i) next_state = last ? DONE : GR_REQ;
            end
            // HOLD keeps a still-asserted command from retriggering.
            DONE:    next_state = dma_enable_i ? HOLD : IDLE;
            HOLD:    if (!dma_enable_i) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        dma_interrupt_o = 1'b0;
        busy_o          = (state != IDLE);
        dram_req_o      = 1'b0;
        dram_we_o       = 1'b0;
        dram_addr_o     = '0;
        dram_wdata_o    = '0;
        dram_wstrb_o    = '0;
        glb_we_o        = 1'b0;
        glb_re_o        = 1'b0;
        glb_addr_o      = '0;
        glb_wdata_o     = '0;
        glb_wstrb_o     = '0;
        unique case (state)
            RD_REQ: begin
                dram_req_o  = 1'b1;
                dram_addr_o = daddr_q;
            end
            GLB_WR: begin
                glb_we_o    = 1'b1;
                glb_addr_o  = gaddr_q;
                glb_wdata_o = data_q;
                glb_wstrb_o = strb;
            end
            GR_REQ: begin
                glb_re_o   = 1'b1;
                glb_addr_o = gaddr_q;
            end
            WR_REQ: begin
                dram_req_o   = 1'b1;
                dram_we_o    = 1'b1;
                dram_addr_o  = daddr_q;
                dram_wdata_o = data_q;
                dram_wstrb_o = strb;
            end
            DONE:    dma_interrupt_o = 1'b1;
            default: ;
        endcase
    end

    assign dma_err_o = err_q;

endmodule

// File: tb/tb_dma_engine.sv
// Directed bench for dma_engine with DRAM/GLB responders and a beat scoreboard.
// Expected beats are queued when a command is issued and popped as the DUT moves data.
module tb_dma_engine;

    typedef struct packed {
        logic        is_glb;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        dma_enable_i = 1'b0;
    logic        dma_read_i = 1'b0;
    logic [31:0] dma_addr_i = '0;
    logic [31:0] dma_len_i = '0;
    logic [15:0] glb_addr_i = '0;
    logic        dma_interrupt_o, dma_err_o, busy_o;
    logic        dram_req_o, dram_we_o;
    logic [31:0] dram_addr_o, dram_wdata_o;
    logic [3:0]  dram_wstrb_o;
    logic        dram_gnt_i = 1'b0;
    logic        dram_rvalid_i = 1'b0;
    logic [31:0] dram_rdata_i = '0;
    logic        glb_we_o, glb_re_o;
    logic [15:0] glb_addr_o;
    logic [31:0] glb_wdata_o;
    logic [3:0]  glb_wstrb_o;
    logic [31:0] glb_rdata_i = '0;

    dma_engine #(.GLB_AW(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .dma_enable_i(dma_enable_i), .dma_read_i(dma_read_i),
        .dma_addr_i(dma_addr_i), .dma_len_i(dma_len_i),
        .glb_addr_i(glb_addr_i),
        .dma_interrupt_o(dma_interrupt_o), .dma_err_o(dma_err_o),
        .busy_o(busy_o),
        .dram_req_o(dram_req_o), .dram_we_o(dram_we_o),
        .dram_addr_o(dram_addr_o), .dram_wdata_o(dram_wdata_o),
        .dram_wstrb_o(dram_wstrb_o), .dram_gnt_i(dram_gnt_i),
        .dram_rvalid_i(dram_rvalid_i), .dram_rdata_i(dram_rdata_i),
        .glb_we_o(glb_we_o), .glb_re_o(glb_re_o),
        .glb_addr_o(glb_addr_o), .glb_wdata_o(glb_wdata_o),
        .glb_wstrb_o(glb_wstrb_o), .glb_rdata_i(glb_rdata_i)
    );

    always #5 clk = ~clk;

    beat_t       sb[$];
    int          vectors = 0;
    int          errs = 0;
    int          cyc = 0;
    int          irq_cnt = 0;
    int          bus_cnt = 0;
    int          gnt_delay = 0;
    int          rv_delay = 0;
    int          g_cnt = 0;
    int          rv_cnt = 0;
    logic        rv_pend = 1'b0;
    logic [31:0] rv_data = '0;
    logic        prev_wait = 1'b0;
    logic [69:0] prev_bundle = '0;

    function automatic logic [31:0] dram_word(input logic [31:0] a);
        return a ^ 32'h1234_5678;
    endfunction

    function automatic logic [31:0] glb_word(input logic [15:0] a);
        return {16'hC0DE, a ^ 16'h5A5A};
    endfunction

    function automatic logic [3:0] exp_strb(input int r);
        logic [3:0] one;
        one = 4'h1;
        if (r >= 4) return 4'hF;
        return (one << r) - 4'h1;
    endfunction

    task automatic check(input string tag, input logic [71:0] obs,
                         input logic [71:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic monitor();
        logic [69:0] bundle;
        beat_t       b, e;
        bundle = {dram_req_o, dram_we_o, dram_addr_o, dram_wdata_o,
                  dram_wstrb_o};
        if (dram_req_o || glb_we_o || glb_re_o) bus_cnt++;
        if (prev_wait && rst_n) check("req_stable", 72'(bundle),
                                      72'(prev_bundle));
        prev_wait   = dram_req_o && !dram_gnt_i && rst_n;
        prev_bundle = bundle;
        if (glb_we_o || (dram_req_o && dram_we_o && dram_gnt_i)) begin
            check("beat_expected", 72'(sb.size() != 0), 72'(1));
            if (sb.size() != 0) begin
                e = sb.pop_front();
                if (glb_we_o)
                    b = '{1'b1, 32'(glb_addr_o), glb_wdata_o, glb_wstrb_o};
                else
                    b = '{1'b0, dram_addr_o, dram_wdata_o, dram_wstrb_o};
                check(b.is_glb ? "glb_wr_beat" : "dram_wr_beat",
                      72'(b), 72'(e));
            end
        end
        if (dma_interrupt_o) irq_cnt++;
    endtask

    // One cycle: responders set inputs at the falling edge, then observe.
    task automatic tick();
        @(negedge clk);
        cyc++;
        dram_rvalid_i = 1'b0;
        dram_rdata_i  = 32'hDEAD_BEEF;
        if (rv_pend) begin
            if (rv_cnt >= rv_delay) begin
                dram_rvalid_i = 1'b1;
                dram_rdata_i  = rv_data;
                rv_pend       = 1'b0;
            end else begin
                rv_cnt++;
            end
        end
        dram_gnt_i = 1'b0;
        if (dram_req_o) begin
            if (g_cnt >= gnt_delay) begin
                dram_gnt_i = 1'b1;
                g_cnt      = 0;
                if (!dram_we_o) begin
                    rv_pend = 1'b1;
                    rv_cnt  = 0;
                    rv_data = dram_word(dram_addr_o);
                end
            end else begin
                g_cnt++;
            end
        end
        if (glb_re_o) glb_rdata_i = glb_word(glb_addr_o);
        monitor();
    endtask

    task automatic push_cmd(input logic rd, input logic [31:0] a,
                            input logic [15:0] g, input int len);
        for (int off = 0; off < len; off += 4) begin
            logic [15:0] ga;
            ga = g + 16'(off);
            if (rd) sb.push_back('{1'b1, 32'(ga), dram_word(a + 32'(off)),
                                   exp_strb(len - off)});
            else    sb.push_back('{1'b0, a + 32'(off), glb_word(ga),
                                   exp_strb(len - off)});
        end
    endtask

    // Issue at the current falling edge; runs until the interrupt.
    task automatic run_cmd(input string tag, input logic rd,
                           input logic [31:0] a, input logic [15:0] g,
                           input int len, input int gd, input int rvd,
                           input int exp_off, input logic exp_err,
                           input logic quiet, input int hold);
        int t0, irq0, bus0;
        gnt_delay = gd;
        rv_delay  = rvd;
        if (!quiet) push_cmd(rd, a, g, len);
        dma_enable_i = 1'b1;
        dma_read_i   = rd;
        dma_addr_i   = a;
        dma_len_i    = 32'(len);
        glb_addr_i   = g;
        t0   = cyc;
        irq0 = irq_cnt;
        bus0 = bus_cnt;
        tick();
        check({tag, "_busy"}, 72'(busy_o), 72'(1));
        while (!dma_interrupt_o && (cyc - t0) < 400) tick();
        check({tag, "_irq_seen"}, 72'(dma_interrupt_o), 72'(1));
        check({tag, "_irq_lat"}, 72'(cyc - t0), 72'(exp_off));
        check({tag, "_err"}, 72'(dma_err_o), 72'(exp_err));
        check({tag, "_sb_empty"}, 72'(sb.size()), 72'(0));
        if (quiet) check({tag, "_quiet"}, 72'(bus_cnt - bus0), 72'(0));
        sb.delete();
        repeat (hold) tick();
        if (hold > 0) check({tag, "_hold_busy"}, 72'(busy_o), 72'(1));
        dma_enable_i = 1'b0;
        tick();
        check({tag, "_idle"}, 72'(busy_o), 72'(0));
        check({tag, "_one_pulse"}, 72'(irq_cnt - irq0), 72'(1));
    endtask

    function automatic logic [71:0] all_outs();
        return 72'({dma_interrupt_o, dma_err_o, busy_o, dram_req_o,
                    dram_we_o, dram_addr_o, dram_wdata_o, dram_wstrb_o,
                    glb_we_o, glb_re_o, glb_addr_o, glb_wdata_o,
                    glb_wstrb_o});
    endfunction

    initial begin
        int t0, b0;
        rst_n = 1'b0;
        tick();
        tick();
        check("reset_outs", all_outs(), 72'(0));
        rst_n = 1'b1;
        tick();

        run_cmd("rd12", 1'b1, 32'h1000, 16'h0040, 12, 0, 0, 10,
                1'b0, 1'b0, 0);
        run_cmd("wr6", 1'b0, 32'h2000, 16'h0010, 6, 0, 0, 7,
                1'b0, 1'b0, 0);
        run_cmd("rd_slow", 1'b1, 32'h1100, 16'h0200, 8, 5, 3, 23,
                1'b0, 1'b0, 0);
        run_cmd("len0", 1'b1, 32'h1000, 16'h0040, 0, 0, 0, 1,
                1'b0, 1'b1, 0);
        run_cmd("misal", 1'b1, 32'h1002, 16'h0040, 8, 0, 0, 1,
                1'b1, 1'b1, 0);
        run_cmd("glb_wrap", 1'b1, 32'h4000, 16'hFFFC, 8, 0, 0, 7,
                1'b0, 1'b0, 0);
        run_cmd("dram_wrap", 1'b0, 32'hFFFF_FFFC, 16'h0020, 8, 2, 0, 11,
                1'b0, 1'b0, 0);
        run_cmd("hold", 1'b1, 32'h5000, 16'h0100, 4, 0, 0, 4,
                1'b0, 1'b0, 4);
        run_cmd("gap", 1'b0, 32'h6000, 16'h0030, 3, 0, 0, 4,
                1'b0, 1'b0, 0);

        // Reset while a read response is outstanding.
        gnt_delay    = 0;
        rv_delay     = 3;
        dma_enable_i = 1'b1;
        dma_read_i   = 1'b1;
        dma_addr_i   = 32'h3000;
        dma_len_i    = 32'd12;
        glb_addr_i   = 16'h0080;
        t0 = cyc;
        do tick(); while (!dram_gnt_i && (cyc - t0) < 50);
        check("rst_gnt_seen", 72'(dram_gnt_i), 72'(1));
        tick();
        rst_n        = 1'b0;
        dma_enable_i = 1'b0;
        tick();
        check("rst_mid_outs", all_outs(), 72'(0));
        rst_n = 1'b1;
        b0 = bus_cnt;
        repeat (6) tick();
        check("rst_late_rvalid", all_outs(), 72'(0));
        check("rst_no_bus", 72'(bus_cnt - b0), 72'(0));
        check("rst_rv_drained", 72'(rv_pend), 72'(0));
        run_cmd("post_rst", 1'b1, 32'h7000, 16'h0300, 12, 0, 0, 10,
                1'b0, 1'b0, 0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, errs);
        $finish;
    end

endmodule
